afu_rd_arbiter: RTL and testbench
=================================

// Module: afu_rd_arbiter
// PURPOSE
//  Shares the single core TX-read channel (cor_tx_rd_*) between NUM_REQ independent read engines inside afu_core.
//  Round-robin grant, gated by spl_tx_rd_almostfull, a request-tag FIFO and a cache-line credit limit.
//  Routes each returning io_rx_rd_valid line back to the requester that issued it, using an in-order tag FIFO.
//  Sits between the core engines and the afu_io request/response ports.
// PARAMETERS
//  NUM_REQ    4    number of requesters (2..8)
//  ADDR_W     58   cache-line address width
//  LEN_W      6    request length field; 0 = 64 CL, n = n CL
//  TAG_DEPTH  16   in-flight requests tracked (power of 2)
//  MAX_LINES  256  max outstanding cache lines across all requesters
// PORTS
//  clk                   in   1               core clock (400 MHz domain)
//  reset_n               in   1               async active-low reset
//  req_valid             in   NUM_REQ         per-requester read request
//  req_addr              in   NUM_REQ*ADDR_W  packed CL addresses, requester i at [i*ADDR_W +: ADDR_W]
//  req_len               in   NUM_REQ*LEN_W   packed lengths
//  req_ready             out  NUM_REQ         one-hot grant; request accepted when valid&ready
//  spl_tx_rd_almostfull  in   1               host read channel backpressure
//  cor_tx_rd_valid       out  1               issued request to afu_io
//  cor_tx_rd_addr        out  ADDR_W          issued address
//  cor_tx_rd_len         out  LEN_W           issued length
//  io_rx_rd_valid        in   1               one returned cache line
//  io_rx_data            in   512             returned line data
//  rsp_valid             out  NUM_REQ         one-hot response strobe
//  rsp_data              out  512             response data, shared by all requesters
//  rsp_last              out  1               final line of the current request
//  outstanding_lines     out  9               current credit usage, 0..MAX_LINES
//  err_unexpected_rsp    out  1               sticky: a line arrived with no request in flight
// BEHAVIOUR
//  Reset (async assert, sync deassert in parent):
//   - All outputs are 0 and the RR pointer is 0.
//   - The tag FIFO is empty, the beat counter is 0 and the error flag is cleared.
//  lines(len) = (len==0) ? 64 : len.
//  can_issue = !spl_tx_rd_almostfull && !tag_full && (outstanding_lines + lines(len_win) <= MAX_LINES).
//  Arbitration (combinational each cycle):
//   - The winner is the first i with req_valid[i], scanning from ptr upward and wrapping.
//   - req_ready[winner] = can_issue; every other req_ready is 0.
//   - req_ready may depend on req_valid; requesters must hold valid/addr/len until ready.
//   - Credit is checked only against the RR winner. There is no skip-ahead to a smaller request, so the scheme is starvation-free.
//  Issue:
//   - On grant, cor_tx_rd_valid/addr/len are registered, giving 1-cycle latency. At most one issue per cycle.
//   - The tag FIFO pushes {winner_id, len}.
//   - ptr <= winner+1 (mod NUM_REQ). The pointer does not move when there is no grant.
//  Response:
//   - The head of the tag FIFO supplies id and len. beat_cnt counts received lines.
//   - Each io_rx_rd_valid produces, one cycle later: rsp_valid[id]=1, rsp_data=io_rx_data, and rsp_last=(beat_cnt+1==lines(len)).
//   - On the last beat: pop the FIFO and set beat_cnt=0; otherwise beat_cnt++.
//   - Responses are required to return in issue order. afu_io guarantees this.
//   - If io_rx_rd_valid arrives with the FIFO empty: set err_unexpected_rsp, drop the data, and leave rsp_valid at 0.
//  Credits:
//   - outstanding_lines += lines(len) on issue and -= 1 per received line.
//   - An issue and a response in the same cycle apply both deltas.
//   - The tag FIFO allows push and pop in the same cycle, including when it is full, because the pop frees the slot first.
//  Boundaries:
//   - almostfull rising stops grants from the next evaluation. A request already registered is still driven.
//   - len=0 consumes 64 credits.
//   - A request whose lines exceed MAX_LINES - outstanding waits and holds the RR pointer.
// STRUCTURE
//  Shared package afu_pkg:
//   - constants CL_W=512, ADDR_W=58, LEN_W=6.
//   - function lines_of(len).
//   - typedef t_rd_tag {id, len}.
//  Sub-module: afu_tag_fifo.
//   - Synchronous FIFO, width $clog2(NUM_REQ)+LEN_W, depth TAG_DEPTH.
//   - Outputs full/empty; simultaneous push and pop are allowed.
//  Top level holds the RR arbiter, output registers, beat counter and credit counter.
// TESTING
//  1 Single: req0 addr=0x100 len=2.
//    -> cor_tx_rd_valid one cycle after grant with addr 0x100, len 2.
//    -> 2 returned lines give rsp_valid=0001 twice, rsp_last on the 2nd; outstanding goes 2 -> 0.
//  2 Fairness: all 4 requesters hold valid with len=1.
//    -> grants 0,1,2,3,0,1 on consecutive cycles.
//  3 Backpressure: assert almostfull for 5 cycles during streaming.
//    -> no req_ready for those 5 cycles; issue resumes the cycle after deassert.
//  4 Credits: req0 len=0 four times (256 lines), then req1 len=1.
//    -> req1 stalls until the 1st line returns, then is granted.
//  5 Ordering: req2 len=3 then req1 len=1.
//    -> 3 lines go to rsp_valid[2] with last on the 3rd, then 1 line to rsp_valid[1] with last.
//  6 Error/reset: a line arrives with nothing in flight -> err_unexpected_rsp=1, no rsp_valid.
//    -> reset_n low mid-burst clears all outputs, the FIFO and the counters asynchronously.

Source files
------------

// File: rtl/afu_pkg.sv
// Shared constants, read-tag layout and the length-to-lines decode for the AFU read path.
// Pure declarations: no latency, no backpressure.
package afu_pkg;

  localparam int CL_W    = 512;
  localparam int ADDR_W  = 58;
  localparam int LEN_W   = 6;
  localparam int LINES_W = 7;
  localparam int ID_W    = 3;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
  } t_rd_tag;

  // A zero length field encodes the maximum 64-line request.
  function automatic logic [LINES_W-1:0] lines_of(input logic [LEN_W-1:0] len);
    return (len == '0) ? 7'd64 : {1'b0, len};
  endfunction

endpackage

// File: rtl/afu_tag_fifo.sv
// Generic synchronous FIFO; head visible combinationally, write-to-read latency 1 cycle.
// Push is ignored when full unless a pop frees the slot in the same cycle; pop is ignored when empty.
module afu_tag_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop   = i_pop && !o_empty;
  assign w_do_push  = i_push && (!o_full || w_do_pop);
  assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

endmodule

// File: rtl/afu_rd_arbiter.sv
// Round-robin share of the core TX-read channel among NUM_REQ engines; issue and response each 1 cycle.
// Grant withheld on almostfull, full tag FIFO or insufficient line credit; responses routed by in-order tags.
module afu_rd_arbiter
  import afu_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TAG_DEPTH = 16,
  parameter int MAX_LINES = 256
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  i_req_len,
  output logic [NUM_REQ-1:0]        o_req_ready,
  input  logic                      i_spl_tx_rd_almostfull,
  output logic                      o_cor_tx_rd_valid,
  output logic [ADDR_W-1:0]         o_cor_tx_rd_addr,
  output logic [LEN_W-1:0]          o_cor_tx_rd_len,
  input  logic                      i_io_rx_rd_valid,
  input  logic [CL_W-1:0]           i_io_rx_data,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [CL_W-1:0]           o_rsp_data,
  output logic                      o_rsp_last,
  output logic [8:0]                o_outstanding_lines,
  output logic                      o_err_unexpected_rsp
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int TAG_W = IDW + LEN_W;

  logic [IDW-1:0]     r_ptr;
  logic               r_tx_vld;
  logic [ADDR_W-1:0]  r_tx_addr;
  logic [LEN_W-1:0]   r_tx_len;
  logic [NUM_REQ-1:0] r_rsp_vld;
  logic [CL_W-1:0]    r_rsp_data;
  logic               r_rsp_last;
  logic [8:0]         r_outstanding;
  logic               r_err;
  logic [LEN_W-1:0]   r_beat;

  logic               w_any;
  logic [IDW-1:0]     w_win;
  logic [ADDR_W-1:0]  w_win_addr;
  logic [LEN_W-1:0]   w_win_len;
  logic [LINES_W-1:0] w_win_lines;
  logic               w_credit_ok;
  logic               w_grant;
  logic               w_tag_full;
  logic               w_tag_empty;
  logic [TAG_W-1:0]   w_tag_head;
  t_rd_tag            w_head;
  logic [LINES_W-1:0] w_head_lines;
  logic               w_rx_hit;
  logic               w_last;
  logic               w_pop;

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // Scan downward so the requester closest to the pointer is the last (winning) assignment.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req_valid[rr_idx(r_ptr, k)]) begin
        w_any = 1'b1;
        w_win = rr_idx(r_ptr, k);
      end
    end
  end

  assign w_win_addr  = i_req_addr[int'(w_win)*ADDR_W +: ADDR_W];
  assign w_win_len   = i_req_len[int'(w_win)*LEN_W +: LEN_W];
  assign w_win_lines = lines_of(w_win_len);
  assign w_credit_ok = ({3'b000, w_win_lines} + {1'b0, r_outstanding}) <= 10'(MAX_LINES);
  assign w_grant     = w_any && !i_spl_tx_rd_almostfull && !w_tag_full && w_credit_ok;
  assign o_req_ready = w_grant ? (NUM_REQ'(1) << w_win) : '0;

  afu_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_push     (w_grant),
    .i_push_dat ({w_win, w_win_len}),
    .i_pop      (w_pop),
    .o_head_dat (w_tag_head),
    .o_full     (w_tag_full),
    .o_empty    (w_tag_empty)
  );

  always_comb begin
    w_head     = '0;
    w_head.id  = ID_W'(w_tag_head[TAG_W-1:LEN_W]);
    w_head.len = w_tag_head[LEN_W-1:0];
  end

  assign w_head_lines = lines_of(w_head.len);
  assign w_rx_hit     = i_io_rx_rd_valid && !w_tag_empty;
  assign w_last       = (({1'b0, r_beat} + 7'd1) == w_head_lines);
  assign w_pop        = w_rx_hit && w_last;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ptr         <= '0;
      r_tx_vld      <= 1'b0;
      r_tx_addr     <= '0;
      r_tx_len      <= '0;
      r_rsp_vld     <= '0;
      r_rsp_data    <= '0;
      r_rsp_last    <= 1'b0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
      r_beat        <= '0;
    end else begin
      r_tx_vld <= w_grant;
      if (w_grant) begin
        r_tx_addr <= w_win_addr;
        r_tx_len  <= w_win_len;
        r_ptr     <= rr_idx(w_win, 1);
      end
      r_rsp_vld  <= w_rx_hit ? (NUM_REQ'(1) << w_head.id) : '0;
      r_rsp_last <= w_rx_hit && w_last;
      if (w_rx_hit) begin
        r_rsp_data <= i_io_rx_data;
        r_beat     <= w_last ? '0 : r_beat + {{(LEN_W-1){1'b0}}, 1'b1};
      end
      // A stray line returns no credit: nothing was charged for it.
      if (i_io_rx_rd_valid && w_tag_empty) r_err <= 1'b1;
      r_outstanding <= r_outstanding + (w_grant ? {2'b00, w_win_lines} : 9'd0) - {8'd0, w_rx_hit};
    end
  end

  assign o_cor_tx_rd_valid    = r_tx_vld;
  assign o_cor_tx_rd_addr     = r_tx_addr;
  assign o_cor_tx_rd_len      = r_tx_len;
  assign o_rsp_valid          = r_rsp_vld;
  assign o_rsp_data           = r_rsp_data;
  assign o_rsp_last           = r_rsp_last;
  assign o_outstanding_lines  = r_outstanding;
  assign o_err_unexpected_rsp = r_err;

endmodule

// File: tb/tb_afu_rd_arbiter.sv
// Bench for afu_rd_arbiter: grant vector table plus issue/response scoreboards.
module tb_afu_rd_arbiter;
  import afu_pkg::*;

  localparam int NR = 4;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NR-1:0]        req_valid;
  logic [NR*ADDR_W-1:0] req_addr;
  logic [NR*LEN_W-1:0]  req_len;
  logic [NR-1:0]        req_ready;
  logic                 af;
  logic                 tx_vld;
  logic [ADDR_W-1:0]    tx_addr;
  logic [LEN_W-1:0]     tx_len;
  logic                 rx_vld;
  logic [CL_W-1:0]      rx_data;
  logic [NR-1:0]        rsp_vld;
  logic [CL_W-1:0]      rsp_data;
  logic                 rsp_last;
  logic [8:0]           outst;
  logic                 err;

  int checks   = 0;
  int failures = 0;

  typedef struct {logic [ADDR_W-1:0] addr; logic [LEN_W-1:0] len;} iss_t;
  typedef struct {logic [NR-1:0] vld; logic [CL_W-1:0] data; logic last;} rsp_t;
  typedef struct {logic [NR-1:0] valid; logic af; logic [NR-1:0] exp_ready;} vec_t;

  iss_t              iss_q[$];
  rsp_t              rsp_q[$];
  int                id_q[$];
  logic [ADDR_W-1:0] addr_of [NR];
  logic [LEN_W-1:0]  len_of [NR];
  vec_t              vecs [18];
  iss_t              mon_iss;
  rsp_t              mon_rsp;

  always #5 clk = ~clk;

  afu_rd_arbiter #(.NUM_REQ(NR), .TAG_DEPTH(16), .MAX_LINES(256)) dut (
    .i_clk                  (clk),
    .i_reset_n              (reset_n),
    .i_req_valid            (req_valid),
    .i_req_addr             (req_addr),
    .i_req_len              (req_len),
    .o_req_ready            (req_ready),
    .i_spl_tx_rd_almostfull (af),
    .o_cor_tx_rd_valid      (tx_vld),
    .o_cor_tx_rd_addr       (tx_addr),
    .o_cor_tx_rd_len        (tx_len),
    .i_io_rx_rd_valid       (rx_vld),
    .i_io_rx_data           (rx_data),
    .o_rsp_valid            (rsp_vld),
    .o_rsp_data             (rsp_data),
    .o_rsp_last             (rsp_last),
    .o_outstanding_lines    (outst),
    .o_err_unexpected_rsp   (err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] l);
    req_valid[i] = v;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_len[i*LEN_W +: LEN_W] = l;
    addr_of[i] = a;
    len_of[i] = l;
  endtask

  task automatic expect_grant(input string name, input logic [NR-1:0] exp);
    iss_t e;
    int   id;
    #1;
    chk(name, 64'(req_ready), 64'(exp));
    if (exp != '0) begin
      id = 0;
      for (int i = 0; i < NR; i++) if (exp[i]) id = i;
      e.addr = addr_of[id];
      e.len  = len_of[id];
      iss_q.push_back(e);
      id_q.push_back(id);
    end
  endtask

  task automatic start_line(input int id, input logic last, input bit expect_rsp);
    rsp_t r;
    for (int j = 0; j < CL_W/32; j++) r.data[j*32 +: 32] = $urandom;
    r.vld = '0;
    r.vld[id] = 1'b1;
    r.last = last;
    rx_vld = 1'b1;
    rx_data = r.data;
    if (expect_rsp) rsp_q.push_back(r);
  endtask

  task automatic line(input int id, input logic last, input bit expect_rsp);
    start_line(id, last, expect_rsp);
    tick();
    rx_vld = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = '0;
    af = 1'b0;
    rx_vld = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (tx_vld) begin
        if (iss_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL issue_unexpected: got addr %0h, none required", tx_addr);
        end else begin
          mon_iss = iss_q.pop_front();
          chk("issue_addr", 64'(tx_addr), 64'(mon_iss.addr));
          chk("issue_len", 64'(tx_len), 64'(mon_iss.len));
        end
      end
      if (rsp_vld != '0) begin
        if (rsp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected: got rsp_valid %0h, none required", rsp_vld);
        end else begin
          mon_rsp = rsp_q.pop_front();
          chk("rsp_valid", 64'(rsp_vld), 64'(mon_rsp.vld));
          chk("rsp_data_lo", rsp_data[63:0], mon_rsp.data[63:0]);
          chk("rsp_data_hi", rsp_data[511:448], mon_rsp.data[511:448]);
          chk("rsp_last", 64'(rsp_last), 64'(mon_rsp.last));
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_len = '0;
    af = 1'b0;
    rx_vld = 1'b0;
    rx_data = '0;
    #2;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_tx_vld", 64'(tx_vld), 64'd0);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst_rsp_last", 64'(rsp_last), 64'd0);
    chk("rst_outst", 64'(outst), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    tick();
    reset_n = 1'b1;

    // Single request, two returned lines
    set_req(0, 1'b1, 58'h100, 6'd2);
    expect_grant("t1_ready", 4'b0001);
    tick();
    set_req(0, 1'b0, 58'h100, 6'd2);
    chk("t1_tx_vld", 64'(tx_vld), 64'd1);
    chk("t1_outst_issue", 64'(outst), 64'd2);
    tick();
    chk("t1_tx_vld_pulse", 64'(tx_vld), 64'd0);
    line(0, 1'b0, 1'b1);
    chk("t1_rsp_vld_latency", 64'(rsp_vld), 64'd1);
    chk("t1_outst_one", 64'(outst), 64'd1);
    line(0, 1'b1, 1'b1);
    chk("t1_rsp_last", 64'(rsp_last), 64'd1);
    chk("t1_outst_zero", 64'(outst), 64'd0);
    tick();

    // Fairness and backpressure table
    do_reset();
    id_q.delete();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, ADDR_W'(58'h1000 + i), 6'd1);
    vecs[0]  = '{4'hF, 1'b0, 4'h1};
    vecs[1]  = '{4'hF, 1'b0, 4'h2};
    vecs[2]  = '{4'hF, 1'b0, 4'h4};
    vecs[3]  = '{4'hF, 1'b0, 4'h8};
    vecs[4]  = '{4'hF, 1'b0, 4'h1};
    vecs[5]  = '{4'hF, 1'b0, 4'h2};
    for (int r = 6; r <= 10; r++) vecs[r] = '{4'hF, 1'b1, 4'h0};
    vecs[11] = '{4'hF, 1'b0, 4'h4};
    vecs[12] = '{4'h5, 1'b0, 4'h1};
    vecs[13] = '{4'h5, 1'b0, 4'h4};
    vecs[14] = '{4'h5, 1'b0, 4'h1};
    vecs[15] = '{4'hA, 1'b0, 4'h2};
    vecs[16] = '{4'h0, 1'b0, 4'h0};
    vecs[17] = '{4'h8, 1'b0, 4'h8};
    for (int r = 0; r < 18; r++) begin
      req_valid = vecs[r].valid;
      af = vecs[r].af;
      expect_grant($sformatf("vec%0d_ready", r), vecs[r].exp_ready);
      tick();
    end
    req_valid = '0;
    af = 1'b0;
    chk("t2_outst", 64'(outst), 64'd12);
    while (id_q.size() > 0) line(id_q.pop_front(), 1'b1, 1'b1);
    tick();
    chk("t2_outst_drained", 64'(outst), 64'd0);

    // Credit limit: four 64-line reads then a 1-line read
    do_reset();
    id_q.delete();
    set_req(0, 1'b1, 58'h2000, 6'd0);
    for (int n = 0; n < 4; n++) begin
      expect_grant($sformatf("t4_grant%0d", n), 4'b0001);
      tick();
    end
    set_req(0, 1'b0, 58'h2000, 6'd0);
    set_req(1, 1'b1, 58'h3000, 6'd1);
    for (int n = 0; n < 3; n++) begin
      expect_grant($sformatf("t4_stall%0d", n), 4'b0000);
      tick();
    end
    chk("t4_outst_full", 64'(outst), 64'd256);
    start_line(0, 1'b0, 1'b1);
    expect_grant("t4_stall_rx", 4'b0000);
    tick();
    rx_vld = 1'b0;
    expect_grant("t4_after_credit", 4'b0010);
    tick();
    set_req(1, 1'b0, 58'h3000, 6'd1);
    for (int b = 1; b < 64; b++) line(0, (b == 63), 1'b1);
    for (int r = 1; r < 4; r++)
      for (int b = 0; b < 64; b++) line(0, (b == 63), 1'b1);
    line(1, 1'b1, 1'b1);
    tick();
    chk("t4_outst_drained", 64'(outst), 64'd0);

    // Ordering across requesters
    set_req(2, 1'b1, 58'h4000, 6'd3);
    expect_grant("t5_req2", 4'b0100);
    tick();
    set_req(2, 1'b0, 58'h4000, 6'd3);
    set_req(1, 1'b1, 58'h5000, 6'd1);
    expect_grant("t5_req1", 4'b0010);
    tick();
    set_req(1, 1'b0, 58'h5000, 6'd1);
    line(2, 1'b0, 1'b1);
    line(2, 1'b0, 1'b1);
    line(2, 1'b1, 1'b1);
    line(1, 1'b1, 1'b1);
    tick();
    chk("t5_outst_drained", 64'(outst), 64'd0);

    // Unexpected line, then asynchronous reset mid-burst
    chk("t6_err_before", 64'(err), 64'd0);
    line(0, 1'b0, 1'b0);
    chk("t6_err_set", 64'(err), 64'd1);
    chk("t6_no_rsp", 64'(rsp_vld), 64'd0);
    chk("t6_outst_stray", 64'(outst), 64'd0);
    tick();
    chk("t6_err_sticky", 64'(err), 64'd1);
    set_req(0, 1'b1, 58'h6000, 6'd4);
    expect_grant("t6_req0", 4'b0001);
    tick();
    set_req(0, 1'b0, 58'h6000, 6'd4);
    line(0, 1'b0, 1'b1);
    start_line(0, 1'b0, 1'b0);
    tick();
    rx_vld = 1'b0;
    chk("t6_burst_rsp", 64'(rsp_vld), 64'd1);
    chk("t6_burst_outst", 64'(outst), 64'd2);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_arst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("t6_arst_rsp_data", rsp_data[63:0], 64'd0);
    chk("t6_arst_outst", 64'(outst), 64'd0);
    chk("t6_arst_err", 64'(err), 64'd0);
    chk("t6_arst_tx_vld", 64'(tx_vld), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    line(0, 1'b0, 1'b0);
    chk("t6_fifo_cleared", 64'(err), 64'd1);
    set_req(0, 1'b1, 58'h7000, 6'd2);
    expect_grant("t6_post_ready", 4'b0001);
    tick();
    set_req(0, 1'b0, 58'h7000, 6'd2);
    line(0, 1'b0, 1'b1);
    line(0, 1'b1, 1'b1);
    tick();
    chk("t6_post_outst", 64'(outst), 64'd0);

    tick();
    chk("iss_q_empty", 64'(iss_q.size()), 64'd0);
    chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
